// File: rtl/mem_router.sv
// ---------------------------------------------------------------------------
// mem_router
// ---------------------------------------------------------------------------
// Routes the arbiter's single memory port to NSLV memory-mapped targets
// (rom, tim, clic, clint, uart, ram, ...) using a configurable region table.
// Only one transaction is outstanding at a time. The router remembers which
// target owns it, so a ready pulse from any other target is ignored. One
// request that arrives while busy is held in a one-deep buffer; a further
// request is dropped and flagged. Unmapped accesses and accesses whose
// target never answers (timeout) complete with an error response.
//
// Parameters:
//   NSLV     number of targets (1..16)
//   BASE     packed table of region base addresses, region i at [32*i +: 32]
//   TOP      packed table of exclusive region tops,  region i at [32*i +: 32]
//   TIMEOUT  cycles to wait for the owner's ready before forcing an error
//            (0 disables the timeout)
//   REBASE   1: target sees addr - BASE[i]; 0: target sees addr unchanged
//
// Ports:
//   clock, reset        clock and asynchronous active-low reset
//   m_valid/m_instr/m_addr/m_wdata/m_wstrb
//                       request pulse and payload from the arbiter
//   m_rdata/m_error/m_ready
//                       one-cycle response back to the arbiter
//   s_valid             one-hot request pulse to the owning target
//   s_instr/s_addr/s_wdata/s_wstrb
//                       request payload shared by all targets
//   s_rdata/s_ready     per-target response data and ready pulses
//   busy                a transaction is outstanding or the buffer is full
//   overflow            sticky flag: a request had to be dropped
//   fault_addr          address of the most recent error response
// ---------------------------------------------------------------------------
module mem_router #(
   parameter int                 NSLV    = 6,
   parameter logic [NSLV*32-1:0] BASE    = {32'h8000_0000, 32'h1000_0000,
                                            32'h0200_0000, 32'h0C00_0000,
                                            32'h0001_0000, 32'h0000_0000},
   parameter logic [NSLV*32-1:0] TOP     = {32'h8001_0000, 32'h1000_1000,
                                            32'h0201_0000, 32'h0C01_0000,
                                            32'h0002_0000, 32'h0001_0000},
   parameter int                 TIMEOUT = 1024,
   parameter bit                 REBASE  = 1'b1
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               m_valid,
   input  logic               m_instr,
   input  logic [31:0]        m_addr,
   input  logic [31:0]        m_wdata,
   input  logic [3:0]         m_wstrb,
   output logic [31:0]        m_rdata,
   output logic               m_error,
   output logic               m_ready,
   output logic [NSLV-1:0]    s_valid,
   output logic               s_instr,
   output logic [31:0]        s_addr,
   output logic [31:0]        s_wdata,
   output logic [3:0]         s_wstrb,
   input  logic [NSLV*32-1:0] s_rdata,
   input  logic [NSLV-1:0]    s_ready,
   output logic               busy,
   output logic               overflow,
   output logic [31:0]        fault_addr
);

   localparam int OW = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   localparam logic [CW-1:0] CNT_LIMIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
   localparam logic [CW-1:0] CNT_MAX   = '1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] ERR  = 2'd2;

   logic [1:0]    state;
   logic [OW-1:0] owner;
   logic [CW-1:0] cnt;
   logic [31:0]   iss_addr;

   logic          buf_full;
   logic          buf_instr;
   logic [31:0]   buf_addr;
   logic [31:0]   buf_wdata;
   logic [3:0]    buf_wstrb;

   logic          issue;
   logic          src_instr;
   logic [31:0]   src_addr;
   logic [31:0]   src_wdata;
   logic [3:0]    src_wstrb;

   logic          hit_any;
   logic [OW-1:0] hit_idx;
   logic [31:0]   hit_base;

   logic          owner_ready;
   logic [31:0]   owner_rdata;
   logic          timeout_hit;
   logic          done_ok;
   logic          done_to;

   // A new transaction can only start from IDLE. A buffered request always
   // has priority over a fresh pulse so requests are served in arrival order.
   always_comb begin
      issue     = (state == IDLE) && (buf_full || m_valid);
      src_instr = buf_full ? buf_instr : m_instr;
      src_addr  = buf_full ? buf_addr  : m_addr;
      src_wdata = buf_full ? buf_wdata : m_wdata;
      src_wstrb = buf_full ? buf_wstrb : m_wstrb;
   end

   // Region decode. The loop runs from the highest index downwards so the
   // last match written is the lowest index, which wins on overlap.
   always_comb begin
      hit_any  = 1'b0;
      hit_idx  = '0;
      hit_base = '0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if ((src_addr >= BASE[32*i +: 32]) && (src_addr < TOP[32*i +: 32])) begin
            hit_any  = 1'b1;
            hit_idx  = OW'(i);
            hit_base = BASE[32*i +: 32];
         end
      end
   end

   // Target-side request. The shared payload is held at zero outside a real
   // issue cycle so idle targets never see stale addresses.
   always_comb begin
      s_valid = '0;
      s_instr = 1'b0;
      s_addr  = '0;
      s_wdata = '0;
      s_wstrb = '0;
      if (issue && hit_any) begin
         for (int i = 0; i < NSLV; i++) begin
            s_valid[i] = (hit_idx == OW'(i));
         end
         s_instr = src_instr;
         s_addr  = REBASE ? (src_addr - hit_base) : src_addr;
         s_wdata = src_wdata;
         s_wstrb = src_wstrb;
      end
   end

   // Select the owner's ready/data. Owner is only meaningful in WAIT, so
   // everything downstream is qualified with the state.
   always_comb begin
      owner_ready = 1'b0;
      owner_rdata = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (owner == OW'(i)) begin
            owner_ready = s_ready[i];
            owner_rdata = s_rdata[32*i +: 32];
         end
      end
   end

   // Response generation. A ready from the owner in the same cycle as the
   // timeout limit is a normal completion, hence the !owner_ready term.
   always_comb begin
      timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LIMIT);
      done_ok     = (state == WAIT) && owner_ready;
      done_to     = (state == WAIT) && !owner_ready && timeout_hit;
      m_ready     = done_ok || done_to || (state == ERR);
      m_error     = done_to || (state == ERR);
      m_rdata     = done_ok ? owner_rdata : '0;
      busy        = (state != IDLE) || buf_full;
   end

   // Transaction FSM: owner, timeout counter, issued address and the fault
   // address. Unmapped issues record the fault immediately; timeouts record
   // the originally issued (not rebased) address when they fire.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         owner      <= '0;
         cnt        <= '0;
         iss_addr   <= '0;
         fault_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (issue) begin
                  iss_addr <= src_addr;
                  if (hit_any) begin
                     owner <= hit_idx;
                     cnt   <= '0;
                     state <= WAIT;
                  end else begin
                     fault_addr <= src_addr;
                     state      <= ERR;
                  end
               end
            end
            WAIT: begin
               if (done_ok || done_to) begin
                  state <= IDLE;
                  if (done_to) begin
                     fault_addr <= iss_addr;
                  end
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            ERR: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // One-deep request buffer. In IDLE a full buffer is being issued this
   // cycle, so a simultaneous pulse simply refills it. Outside IDLE a pulse
   // fills an empty buffer or, if it is already full, is dropped and the
   // sticky overflow flag is raised.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         buf_full  <= 1'b0;
         buf_instr <= 1'b0;
         buf_addr  <= '0;
         buf_wdata <= '0;
         buf_wstrb <= '0;
         overflow  <= 1'b0;
      end else if (state == IDLE) begin
         if (buf_full) begin
            if (m_valid) begin
               buf_instr <= m_instr;
               buf_addr  <= m_addr;
               buf_wdata <= m_wdata;
               buf_wstrb <= m_wstrb;
            end else begin
               buf_full <= 1'b0;
            end
         end
      end else if (m_valid) begin
         if (!buf_full) begin
            buf_full  <= 1'b1;
            buf_instr <= m_instr;
            buf_addr  <= m_addr;
            buf_wdata <= m_wdata;
            buf_wstrb <= m_wstrb;
         end else begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_router.sv
// ---------------------------------------------------------------------------
// tb_mem_router
// ---------------------------------------------------------------------------
// Bench for mem_router with two regions (0x0000_0000-0x0000_1000 and
// 0x1000_0000-0x1000_0100), REBASE=1 and TIMEOUT=8. A transaction-level
// reference model (one outstanding record, a request queue, cycle stamps)
// predicts every output each cycle. Directed steps exercise the listed
// scenarios, then a randomized phase drives request pulses and target
// ready pulses.
// ---------------------------------------------------------------------------
module tb_mem_router;

   localparam int                 NSLV    = 2;
   localparam int                 TIMEOUT = 8;
   localparam logic [NSLV*32-1:0] BASE_V  = {32'h1000_0000, 32'h0000_0000};
   localparam logic [NSLV*32-1:0] TOP_V   = {32'h1000_0100, 32'h0000_1000};

   logic               clock = 1'b0;
   logic               reset;
   logic               m_valid;
   logic               m_instr;
   logic [31:0]        m_addr;
   logic [31:0]        m_wdata;
   logic [3:0]         m_wstrb;
   logic [31:0]        m_rdata;
   logic               m_error;
   logic               m_ready;
   logic [NSLV-1:0]    s_valid;
   logic               s_instr;
   logic [31:0]        s_addr;
   logic [31:0]        s_wdata;
   logic [3:0]         s_wstrb;
   logic [NSLV*32-1:0] s_rdata;
   logic [NSLV-1:0]    s_ready;
   logic               busy;
   logic               overflow;
   logic [31:0]        fault_addr;

   mem_router #(
      .NSLV    (NSLV),
      .BASE    (BASE_V),
      .TOP     (TOP_V),
      .TIMEOUT (TIMEOUT),
      .REBASE  (1'b1)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .m_valid    (m_valid),
      .m_instr    (m_instr),
      .m_addr     (m_addr),
      .m_wdata    (m_wdata),
      .m_wstrb    (m_wstrb),
      .m_rdata    (m_rdata),
      .m_error    (m_error),
      .m_ready    (m_ready),
      .s_valid    (s_valid),
      .s_instr    (s_instr),
      .s_addr     (s_addr),
      .s_wdata    (s_wdata),
      .s_wstrb    (s_wstrb),
      .s_rdata    (s_rdata),
      .s_ready    (s_ready),
      .busy       (busy),
      .overflow   (overflow),
      .fault_addr (fault_addr)
   );

   always #5 clock = ~clock;

   // Region table as the model sees it
   logic [31:0] rbase [NSLV] = '{32'h0000_0000, 32'h1000_0000};
   logic [31:0] rtop  [NSLV] = '{32'h0000_1000, 32'h1000_0100};

   typedef struct {
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   // Reference model state
   req_t        pend [$];
   bit          outst     = 1'b0;
   int          tgt       = -1;
   int          iss_cyc   = 0;
   logic [31:0] iss_addr_m = '0;
   bit          ovf_m     = 1'b0;
   logic [31:0] fault_m   = '0;
   int          cyc_no    = 0;

   // Per-cycle decisions made by checkOutput and consumed at the clock edge
   bit          e_issue;
   bit          e_from_buf;
   int          e_t;
   bit          e_done;
   bit          e_to;
   req_t        e_src;

   int checks = 0;
   int errors = 0;

   function automatic int decode(input logic [31:0] a);
      for (int i = 0; i < NSLV; i++) begin
         if (a >= rbase[i] && a < rtop[i]) return i;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input bit mv, input logic [31:0] a, input logic [1:0] sr,
                                input logic [31:0] rd0, input logic [31:0] rd1);
      m_valid = mv;
      m_addr  = mv ? a : 32'h0;
      m_instr = mv ? 1'($urandom) : 1'b0;
      m_wdata = mv ? $urandom : 32'h0;
      m_wstrb = mv ? 4'($urandom) : 4'h0;
      s_ready = sr;
      s_rdata = {rd1, rd0};
   endtask

   // Predict this cycle's outputs from the model and compare every output
   task automatic checkOutput();
      logic [1:0]  ev;
      logic [31:0] ea, ewd, erd;
      logic [3:0]  ews;
      logic        ei, er, ee;
      #1;
      e_issue = 0; e_from_buf = 0; e_t = -1; e_done = 0; e_to = 0;
      ev = '0; ea = '0; ewd = '0; ews = '0; ei = 1'b0; er = 1'b0; ee = 1'b0; erd = '0;
      if (reset) begin
         if (!outst) begin
            if (pend.size() > 0) begin
               e_issue = 1; e_from_buf = 1; e_src = pend[0];
            end else if (m_valid) begin
               e_issue = 1; e_src = '{m_instr, m_addr, m_wdata, m_wstrb};
            end
            if (e_issue) begin
               e_t = decode(e_src.addr);
               if (e_t >= 0) begin
                  ev  = 2'(1 << e_t);
                  ea  = e_src.addr - rbase[e_t];
                  ei  = e_src.instr;
                  ewd = e_src.wdata;
                  ews = e_src.wstrb;
               end
            end
         end else if (tgt < 0) begin
            er = 1; ee = 1; e_done = 1;
         end else if (s_ready[tgt]) begin
            er = 1; erd = s_rdata[32*tgt +: 32]; e_done = 1;
         end else if (cyc_no - iss_cyc == TIMEOUT) begin
            er = 1; ee = 1; e_done = 1; e_to = 1;
         end
      end
      chk("m_ready",    {31'b0, m_ready},  {31'b0, er});
      chk("m_error",    {31'b0, m_error},  {31'b0, ee});
      chk("m_rdata",    m_rdata,           erd);
      chk("s_valid",    {30'b0, s_valid},  {30'b0, ev});
      chk("s_instr",    {31'b0, s_instr},  {31'b0, ei});
      chk("s_addr",     s_addr,            ea);
      chk("s_wdata",    s_wdata,           ewd);
      chk("s_wstrb",    {28'b0, s_wstrb},  {28'b0, ews});
      chk("busy",       {31'b0, busy},     {31'b0, (outst || pend.size() > 0)});
      chk("overflow",   {31'b0, overflow}, {31'b0, ovf_m});
      chk("fault_addr", fault_addr,        fault_m);
   endtask

   // Clock edge: advance the model exactly as the transaction rules say
   task automatic advance();
      req_t cur;
      @(posedge clock);
      cur = '{m_instr, m_addr, m_wdata, m_wstrb};
      if (reset) begin
         if (!outst) begin
            if (e_issue) begin
               if (e_from_buf) begin
                  void'(pend.pop_front());
                  if (m_valid) pend.push_back(cur);
               end
               outst      = 1;
               tgt        = e_t;
               iss_cyc    = cyc_no;
               iss_addr_m = e_src.addr;
               if (e_t < 0) fault_m = e_src.addr;
            end
         end else begin
            if (m_valid) begin
               if (pend.size() == 0) pend.push_back(cur);
               else ovf_m = 1;
            end
            if (e_done) begin
               outst = 0;
               if (e_to) fault_m = iss_addr_m;
            end
         end
      end
      cyc_no++;
      @(negedge clock);
   endtask

   task automatic step(input bit mv, input logic [31:0] a, input logic [1:0] sr);
      applyStimulus(mv, a, sr, $urandom, $urandom);
      checkOutput();
   endtask

   task automatic modelReset();
      pend.delete();
      outst   = 0;
      tgt     = -1;
      ovf_m   = 0;
      fault_m = '0;
   endtask

   initial begin
      logic [31:0] ra;
      logic [1:0]  rs;
      reset = 1'b0;
      applyStimulus(0, 0, 2'b00, 0, 0);
      @(negedge clock);

      $display("[TB] reset values");
      for (int i = 0; i < 2; i++) begin
         checkOutput();
         advance();
      end
      reset = 1'b1;

      $display("[TB] mapped read, owner ready after 3 cycles");
      step(1, 32'h1000_0010, 2'b00);
      chk("dir_s_valid", {30'b0, s_valid}, 32'h2);
      chk("dir_s_addr", s_addr, 32'h10);
      advance();
      step(0, 0, 2'b00); advance();
      step(0, 0, 2'b00); advance();
      applyStimulus(0, 0, 2'b10, 32'h0, 32'hDEAD_BEEF);
      checkOutput();
      chk("dir_ready", {31'b0, m_ready}, 32'h1);
      chk("dir_rdata", m_rdata, 32'hDEAD_BEEF);
      chk("dir_error", {31'b0, m_error}, 32'h0);
      advance();

      $display("[TB] unmapped read");
      step(1, 32'h2000_0000, 2'b00);
      chk("unm_s_valid", {30'b0, s_valid}, 32'h0);
      advance();
      step(0, 0, 2'b00);
      chk("unm_ready", {31'b0, m_ready}, 32'h1);
      chk("unm_error", {31'b0, m_error}, 32'h1);
      chk("unm_rdata", m_rdata, 32'h0);
      chk("unm_fault", fault_addr, 32'h2000_0000);
      advance();

      $display("[TB] timeout and late ready");
      step(1, 32'h0000_0100, 2'b00); advance();
      for (int i = 1; i < TIMEOUT; i++) begin
         step(0, 0, 2'b00);
         chk("to_early", {31'b0, m_ready}, 32'h0);
         advance();
      end
      step(0, 0, 2'b00);
      chk("to_ready", {31'b0, m_ready}, 32'h1);
      chk("to_error", {31'b0, m_error}, 32'h1);
      advance();
      step(0, 0, 2'b00);
      chk("to_fault", fault_addr, 32'h0000_0100);
      advance();
      step(0, 0, 2'b01);
      chk("to_late", {31'b0, m_ready}, 32'h0);
      advance();

      $display("[TB] buffering and overflow");
      step(1, 32'h0000_0200, 2'b00); advance();
      step(1, 32'h1000_0020, 2'b00); advance();
      step(1, 32'h0000_0300, 2'b00); advance();
      step(0, 0, 2'b01);
      chk("buf_a_done", {31'b0, m_ready}, 32'h1);
      chk("buf_ovf", {31'b0, overflow}, 32'h1);
      advance();
      step(0, 0, 2'b00);
      chk("buf_b_issue", {30'b0, s_valid}, 32'h2);
      chk("buf_b_addr", s_addr, 32'h20);
      advance();
      step(0, 0, 2'b10); advance();

      $display("[TB] non-owner ready and ready at timeout limit");
      step(1, 32'h0000_0040, 2'b00); advance();
      step(0, 0, 2'b10);
      chk("nonowner", {31'b0, m_ready}, 32'h0);
      advance();
      for (int i = 2; i < TIMEOUT; i++) begin
         step(0, 0, 2'b00); advance();
      end
      step(0, 0, 2'b01);
      chk("tie_ready", {31'b0, m_ready}, 32'h1);
      chk("tie_error", {31'b0, m_error}, 32'h0);
      advance();

      $display("[TB] reset mid-transaction with full buffer");
      step(1, 32'h0000_0080, 2'b00); advance();
      step(1, 32'h1000_0000, 2'b00);
      chk("rst_pre_busy", {31'b0, busy}, 32'h1);
      advance();
      applyStimulus(0, 0, 2'b00, 0, 0);
      reset = 1'b0;
      modelReset();
      checkOutput();
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_ovf", {31'b0, overflow}, 32'h0);
      advance();
      reset = 1'b1;
      step(0, 0, 2'b01);
      chk("rst_late", {31'b0, m_ready}, 32'h0);
      advance();
      step(0, 0, 2'b00); advance();

      $display("[TB] randomized traffic");
      for (int n = 0; n < 800; n++) begin
         case ($urandom % 6)
            0:       ra = $urandom % 32'h1000;
            1:       ra = 32'h1000_0000 + ($urandom % 32'h100);
            2:       ra = 32'h0000_1000;
            3:       ra = 32'h1000_00FF;
            4:       ra = $urandom;
            default: ra = 32'h0000_0FFF;
         endcase
         rs[0] = (($urandom % 4) == 0);
         rs[1] = (($urandom % 4) == 0);
         step(($urandom % 3) == 0, ra, rs);
         advance();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_router.md
# mem_router

Parametrised address router between the arbiter's single memory port and NSLV memory-mapped targets such as rom, tim, clic, clint, uart and ram. It generalises the fixed SoC decoder in four ways: a configurable region table, per-transaction owner tracking, a one-deep request buffer and a response timeout. Responses are accepted only from the target that owns the transaction. Unmapped and timed-out accesses complete with an error response.

## Interface
Parameters:
- NSLV, 6, number of targets (1..16)
- BASE, packed NSLV×32 bits, region i base address is BASE[32*i +: 32]
- TOP, packed NSLV×32 bits, region i exclusive top address is TOP[32*i +: 32]
- TIMEOUT, 1024, cycles to wait for a target ready before forcing an error; 0 disables the timeout
- REBASE, 1, when 1 the target address is addr − BASE[i]; when 0 the address passes through unchanged

Ports:
- clock  in  1  only clock
- reset  in  1  asynchronous, active-low
- m_valid  in  1  one-cycle request pulse from the arbiter
- m_instr  in  1  instruction-fetch qualifier
- m_addr  in  32  request address
- m_wdata  in  32  write data
- m_wstrb  in  4  byte strobes; all zero means read
- m_rdata  out  32  response data
- m_error  out  1  error response flag
- m_ready  out  1  one-cycle response pulse
- s_valid  out  NSLV  one-hot request pulse to targets
- s_instr  out  1  shared to all targets
- s_addr  out  32  shared to all targets
- s_wdata  out  32  shared to all targets
- s_wstrb  out  4  shared to all targets
- s_rdata  in  NSLV×32  target i data is s_rdata[32*i +: 32]
- s_ready  in  NSLV  target response pulses
- busy  out  1  a transaction is outstanding
- overflow  out  1  sticky: a request was dropped
- fault_addr  out  32  address of the most recent error response

## Operation
- Decode: region i hits when BASE[i] ≤ addr < TOP[i] (unsigned). On overlapping regions the lowest index wins. No hit means unmapped.
- FSM states:
  - IDLE: no transaction outstanding.
  - WAIT: a request has been issued to target `owner`.
  - ERR: an error response is scheduled.
- Issue source in IDLE:
  - If the buffer is full, the buffered request is issued.
  - Otherwise a request is issued directly when m_valid=1.
- Issue to a hit target: s_valid[i]=1 in the issue cycle. s_instr, s_addr, s_wdata and s_wstrb come from the issue source. owner←i, timeout counter←0, go to WAIT.
- Issue to an unmapped address: no s_valid. fault_addr←addr, go to ERR.
- WAIT, normal completion: when s_ready[owner]=1, m_ready=1, m_rdata=s_rdata[owner], m_error=0, go to IDLE.
- WAIT, other targets: s_ready from any non-owner target is ignored.
- WAIT, timeout: when the counter reaches TIMEOUT−1 without s_ready[owner], m_ready=1, m_error=1, m_rdata=0, fault_addr←issued address, go to IDLE. A late s_ready from that target is later ignored, because owner is only valid in WAIT.
- ERR: m_ready=1, m_error=1, m_rdata=0, go to IDLE.
- m_valid arriving while WAIT or ERR is captured into the buffer.
- m_valid arriving while the buffer is full:
  - If the buffer is being issued in the same cycle, the buffer is refilled with the new request.
  - Otherwise the request is dropped and overflow←1.
- Addressing: s_addr = REBASE ? addr − BASE[owner] : addr. Wrap-around modulo 2^32.
- The timeout counter is $clog2(TIMEOUT+1) bits wide and saturates.
- busy = (state != IDLE) or buffer full.

## Timing
- Reset (reset=0, asynchronous) forces:
  - state IDLE, buffer empty, counter 0
  - overflow=0, fault_addr=0
  - m_ready=0, m_error=0, m_rdata=0, s_valid=0
- Reset asserted mid-transaction abandons it. No response is returned, and a later target ready is ignored.
- Direct issue: s_valid is combinational from m_valid, giving zero added latency. Response latency equals the target's ready latency.
- Buffered issue: issued one cycle after the completion of the outstanding transaction.
- Unmapped access: m_ready with m_error=1 exactly 1 cycle after the issue cycle.
- Timeout: error response in cycle TIMEOUT after issue, counting the issue cycle as cycle 0.
- Simultaneous s_ready[owner] and timeout in the same cycle: the normal response wins.
- m_valid in the same cycle as a completion is buffered; it is never issued in that cycle.
- m_ready is never asserted in two consecutive cycles for the same transaction.

## Test plan
- Regions 0x0000_0000–0x0000_1000 and 0x1000_0000–0x1000_0100, REBASE=1. Read 0x1000_0010 → s_valid=2'b10, s_addr=0x10. Target 1 ready after 3 cycles with 0xDEAD_BEEF → m_ready, m_rdata=0xDEAD_BEEF, m_error=0.
- Read 0x2000_0000 (unmapped) → no s_valid. Next cycle m_ready=1, m_error=1, m_rdata=0, fault_addr=0x2000_0000.
- TIMEOUT=8, target never ready → m_error response in cycle 8. Target ready injected in cycle 10 → no m_ready.
- Request A outstanding, request B pulsed → B issued 1 cycle after A's m_ready. Third pulse while A outstanding and B buffered → dropped, overflow=1.
- Non-owner s_ready pulse during WAIT → no m_ready. s_ready[owner] and the timeout limit in the same cycle → m_error=0.
- Assert reset while WAIT with the buffer full → all outputs 0 and busy=0. A subsequent target ready produces no response.
